// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_tx byte transmitter between N_REQ
// requesters. A granted message is latched whole, then fed to uart_tx one
// byte at a time (byte 0 first) over the valid_in/ready_out handshake.
module uart_tx_scheduler #(
    parameter int N_REQ     = 4,
    parameter int MSG_BYTES = 4,
    parameter int BITS_N    = 8,
    parameter int GAP_CLKS  = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_REQ-1:0]                    req_valid,
    input  logic [N_REQ*MSG_BYTES*BITS_N-1:0]   req_data,
    output logic [N_REQ-1:0]                    req_ready,
    output logic [BITS_N-1:0]                   tx_data,
    output logic                                tx_valid,
    input  logic                                tx_ready,
    output logic                                busy,
    output logic [$clog2(N_REQ)-1:0]            grant_id,
    output logic                                msg_done
);

    localparam int GID_W = $clog2(N_REQ);
    localparam int IDX_W = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam int MSG_W = MSG_BYTES * BITS_N;
    localparam int GAP_W = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND      = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MSG_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_END   = GAP_W'(GAP_CLKS);
    localparam logic [GID_W-1:0] LAST_REQ  = GID_W'(N_REQ - 1);
    localparam logic [GID_W:0]   N_REQ_EXT = (GID_W + 1)'(N_REQ);

    logic [2:0]       state_q,      state_d;
    logic [MSG_W-1:0] buf_q,        buf_d;
    logic [IDX_W-1:0] idx_q,        idx_d;
    logic [GID_W-1:0] grant_q,      grant_d;
    logic [GID_W-1:0] last_grant_q, last_grant_d;
    logic [GAP_W-1:0] gap_q,        gap_d;
    logic             busy_q,       busy_d;
    logic             tx_valid_q,   tx_valid_d;
    logic [BITS_N-1:0] tx_data_q,   tx_data_d;
    logic             msg_done_q,   msg_done_d;

    logic             pick_found_s;
    logic [GID_W-1:0] pick_id_s;
    logic [GID_W:0]   cand_sum_s;
    logic [GID_W-1:0] cand_id_s;
    logic [N_REQ-1:0] req_ready_s;
    logic [IDX_W-1:0] nxt_idx_s;

    // Round-robin pick: first set req_valid bit searching upward from last_grant+1 with wrap.
    always_comb begin
        pick_found_s = 1'b0;
        pick_id_s    = '0;
        cand_sum_s   = '0;
        cand_id_s    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_sum_s = {1'b0, last_grant_q} + (GID_W + 1)'(k);
            if (cand_sum_s >= N_REQ_EXT) begin
                cand_sum_s = cand_sum_s - N_REQ_EXT;
            end else begin
                cand_sum_s = cand_sum_s;
            end
            cand_id_s = cand_sum_s[GID_W-1:0];
            if (!pick_found_s && req_valid[cand_id_s]) begin
                pick_found_s = 1'b1;
                pick_id_s    = cand_id_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Accept pulse goes straight to the picked requester while IDLE.
    always_comb begin
        req_ready_s = '0;
        if ((state_q == ST_IDLE) && pick_found_s) begin
            req_ready_s[pick_id_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Next-state and datapath updates for the message sequencer.
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        idx_d        = idx_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        gap_d        = gap_q;
        busy_d       = busy_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        msg_done_d   = 1'b0;
        nxt_idx_s    = idx_q + IDX_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    buf_d      = req_data[pick_id_s*MSG_W +: MSG_W];
                    tx_data_d  = req_data[pick_id_s*MSG_W +: BITS_N];
                    tx_valid_d = 1'b1;
                    grant_d    = pick_id_s;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_WAIT_ACK;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_WAIT_ACK: begin
                // uart_tx drops ready once it has left its idle state
                if (!tx_ready) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_ready) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d      = nxt_idx_s;
                        tx_data_d  = buf_q[nxt_idx_s*BITS_N +: BITS_N];
                        tx_valid_d = 1'b1;
                        state_d    = ST_SEND;
                    end else begin
                        msg_done_d   = 1'b1;
                        last_grant_d = grant_q;
                        gap_d        = '0;
                        state_d      = ST_GAP;
                    end
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_END) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; requester 0 has top priority after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            buf_q        <= '0;
            idx_q        <= '0;
            grant_q      <= '0;
            last_grant_q <= LAST_REQ;
            gap_q        <= '0;
            busy_q       <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            msg_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            idx_q        <= idx_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            gap_q        <= gap_d;
            busy_q       <= busy_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            msg_done_q   <= msg_done_d;
        end
    end

    assign req_ready = req_ready_s;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;
    assign msg_done  = msg_done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: table of arbitration vectors plus hand-written
// stall, mid-message reset and back-to-back gap sequences, with a simple
// uart_tx stand-in and a byte scoreboard.
module tb_uart_tx_scheduler;

    localparam int N_REQ     = 4;
    localparam int MSG_BYTES = 4;
    localparam int BITS_N    = 8;
    localparam int GAP_CLKS  = 10;
    localparam int FRAME     = 12;
    localparam int BUDGET    = 2000;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic [1:0]   grant_id;
    logic         msg_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int uart_cnt = 0;
    logic uart_hs = 1'b0;
    logic stall;

    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];

    typedef struct {
        logic [3:0]  mask;
        int          gid;
        logic [31:0] word;
    } vec_t;
    vec_t tbl [11];

    uart_tx_scheduler #(
        .N_REQ(N_REQ), .MSG_BYTES(MSG_BYTES), .BITS_N(BITS_N), .GAP_CLKS(GAP_CLKS)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .grant_id(grant_id), .msg_done(msg_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx stand-in: ready only while idle; a handshake makes it busy for FRAME clocks.
    assign tx_ready = (uart_cnt == 0) && !stall;

    always @(negedge clk) begin
        if (rst) begin
            uart_cnt <= 0;
            uart_hs  <= 1'b0;
        end else begin
            uart_hs <= 1'b0;
            if (uart_hs) uart_cnt <= FRAME;
            else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
            if (tx_valid && tx_ready && !uart_hs) begin
                uart_hs <= 1'b1;
                cap_q.push_back(tx_data);
            end
        end
        if (msg_done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out after %0d cycles", name, BUDGET);
    endtask

    task automatic push_msg(input int r);
        for (int k = 0; k < MSG_BYTES; k++) exp_q.push_back(req_data[r*32 + k*8 +: 8]);
    endtask

    // Drain the scoreboard, comparing captured bytes in order against expected.
    task automatic compare_msg(input string name);
        logic [7:0] e;
        logic [7:0] a;
        check({name, " nbytes"}, 32'(cap_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && cap_q.size() > 0) begin
            e = exp_q.pop_front();
            a = cap_q.pop_front();
            check({name, " byte"}, {24'h0, a}, {24'h0, e});
        end
        exp_q.delete();
        cap_q.delete();
    endtask

    // Wait (from a negedge) for the accept pulse and check it and the grant.
    task automatic do_accept(input int g, input string name, output int acc_cyc);
        int w;
        logic [3:0] oh;
        w = 0;
        #1;
        while (req_ready == 4'b0000 && w < BUDGET) begin
            @(negedge clk);
            #1;
            w++;
        end
        acc_cyc = cyc;
        if (req_ready == 4'b0000) begin
            timeout({name, " accept"});
            return;
        end
        oh = 4'b0001 << g;
        check({name, " req_ready"}, {28'h0, req_ready}, {28'h0, oh});
        push_msg(g);
        @(negedge clk);
        check({name, " grant_id"}, {30'h0, grant_id}, g);
        check({name, " busy"}, {31'h0, busy}, 32'd1);
        check({name, " ready pulse"}, {28'h0, req_ready}, 32'd0);
        // new data after accept must not disturb the message in flight
        req_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input string name, output int d_cyc);
        int w;
        w = 0;
        while (msg_done !== 1'b1 && w < BUDGET) begin
            @(negedge clk);
            w++;
        end
        d_cyc = cyc;
        if (msg_done !== 1'b1) begin
            timeout({name, " msg_done"});
            return;
        end
        @(negedge clk);
        check({name, " done pulse"}, {31'h0, msg_done}, 32'd0);
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while (busy !== 1'b0 && w < BUDGET) begin
            @(negedge clk);
            w++;
        end
        check({name, " busy clear"}, {31'h0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_c;
        int done_c;
        int prev_done;
        int dc0;
        int w;
        logic [7:0] held;
        int seq [5];

        tbl[0]  = '{4'b0001, 0, 32'hA1B2C3D4};
        tbl[1]  = '{4'b1111, 1, 32'h11223344};
        tbl[2]  = '{4'b1111, 2, 32'h55667788};
        tbl[3]  = '{4'b0101, 0, 32'h99AABBCC};
        tbl[4]  = '{4'b1000, 3, 32'hDEADBEEF};
        tbl[5]  = '{4'b0110, 1, 32'h0F1E2D3C};
        tbl[6]  = '{4'b0110, 2, 32'hFF00FF00};
        tbl[7]  = '{4'b1001, 3, 32'h01020304};
        tbl[8]  = '{4'b0011, 0, 32'hCAFEF00D};
        tbl[9]  = '{4'b0010, 1, 32'h5A5AA5A5};
        tbl[10] = '{4'b0010, 1, 32'h13579BDF};
        seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 3; seq[4] = 0;

        rst = 1'b1;
        stall = 1'b0;
        req_valid = 4'b0000;
        req_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset tx_valid", {31'h0, tx_valid}, 32'd0);
        check("reset tx_data", {24'h0, tx_data}, 32'd0);
        check("reset req_ready", {28'h0, req_ready}, 32'd0);
        check("reset busy", {31'h0, busy}, 32'd0);
        check("reset grant_id", {30'h0, grant_id}, 32'd0);
        check("reset msg_done", {31'h0, msg_done}, 32'd0);

        // Table of arbitration vectors, one whole message each.
        for (int i = 0; i < 11; i++) begin
            req_data = {$urandom, $urandom, $urandom, $urandom};
            req_data[tbl[i].gid*32 +: 32] = tbl[i].word;
            req_valid = tbl[i].mask;
            do_accept(tbl[i].gid, $sformatf("vec%0d", i), acc_c);
            req_valid = 4'b0000;
            dc0 = done_cnt;
            wait_done($sformatf("vec%0d", i), done_c);
            compare_msg($sformatf("vec%0d", i));
            wait_idle($sformatf("vec%0d", i));
            check($sformatf("vec%0d done count", i), done_cnt - dc0, 32'd1);
        end

        // uart_tx held not-ready: byte must sit on tx_data with tx_valid high.
        stall = 1'b1;
        req_data = {$urandom, $urandom, $urandom, $urandom};
        req_valid = 4'b0010;
        do_accept(1, "stall", acc_c);
        req_valid = 4'b0000;
        held = exp_q[0];
        for (int i = 0; i < 50; i++) begin
            check("stall tx_valid", {31'h0, tx_valid}, 32'd1);
            check("stall tx_data", {24'h0, tx_data}, {24'h0, held});
            @(negedge clk);
        end
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("stall release tx_valid", {31'h0, tx_valid}, 32'd0);
        wait_done("stall", done_c);
        compare_msg("stall");
        wait_idle("stall");

        // Reset while byte 2 is being offered: message dropped, no msg_done.
        req_data = {$urandom, $urandom, $urandom, $urandom};
        req_valid = 4'b0100;
        do_accept(2, "midrst", acc_c);
        req_valid = 4'b0000;
        w = 0;
        while (!(cap_q.size() >= 2 && tx_valid === 1'b1) && w < BUDGET) begin
            @(negedge clk);
            w++;
        end
        if (!(cap_q.size() >= 2 && tx_valid === 1'b1)) timeout("midrst byte2");
        dc0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst tx_valid", {31'h0, tx_valid}, 32'd0);
        check("midrst busy", {31'h0, busy}, 32'd0);
        check("midrst grant_id", {30'h0, grant_id}, 32'd0);
        repeat (100) @(negedge clk);
        check("midrst no msg_done", done_cnt - dc0, 32'd0);
        check("midrst tx_valid later", {31'h0, tx_valid}, 32'd0);
        exp_q.delete();
        cap_q.delete();

        // All requesters held: grants 0,1,2,3,0 with GAP_CLKS+1 clocks from msg_done to accept.
        req_data = {$urandom, $urandom, $urandom, $urandom};
        req_valid = 4'b1111;
        prev_done = 0;
        for (int i = 0; i < 5; i++) begin
            do_accept(seq[i], $sformatf("rr%0d", i), acc_c);
            if (i > 0) check($sformatf("rr%0d gap", i), acc_c - prev_done, GAP_CLKS + 1);
            if (i == 4) req_valid = 4'b0000;
            wait_done($sformatf("rr%0d", i), done_c);
            prev_done = done_c;
            compare_msg($sformatf("rr%0d", i));
        end
        wait_idle("rr end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
